// File: rtl/dag_pkg.sv
// Shared types for the DAG access controller: sequencer states, requester ids,
// and the DAG register-index width.
package dag_pkg;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bs_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_BS   = 1'b1
    } req_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (bit 0 = core, bit 1 = block sequencer) with a
// hold input that blocks all grants; the pointer names the requester that wins a tie.
module rr_arb2
    import dag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_hold,
    output logic [1:0] o_gnt,
    output req_e       o_ptr
);
    req_e r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (!i_hold) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = (r_ptr == REQ_CORE) ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    // The winner hands priority to the other requester; no grant leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= REQ_CORE;
        end else if (o_gnt[0]) begin
            r_ptr <= REQ_BS;
        end else if (o_gnt[1]) begin
            r_ptr <= REQ_CORE;
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/dag_ctl.sv
// DAG access controller: merges single core accesses with a block sequencer
// that issues a counted burst of post-modify accesses, one access per cycle max.
module dag_ctl
    import dag_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_req,
    input  logic             core_dgsclt,
    input  logic             core_mdfy,
    input  logic [IDX_W-1:0] core_iadd,
    input  logic [IDX_W-1:0] core_madd,
    output logic             core_gnt,
    input  logic             bs_start,
    input  logic             bs_dgsclt,
    input  logic [IDX_W-1:0] bs_iadd,
    input  logic [IDX_W-1:0] bs_madd,
    input  logic [CNT_W-1:0] bs_cnt,
    output logic             bs_busy,
    output logic             bs_done,
    input  logic             dg_hold,
    output logic             ps_dg_en,
    output logic             ps_dg_dgsclt,
    output logic             ps_dg_mdfy,
    output logic [IDX_W-1:0] ps_dg_iadd,
    output logic [IDX_W-1:0] ps_dg_madd
);
    bs_state_e        r_state;
    bs_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bs_dgsclt;
    logic [IDX_W-1:0] r_bs_iadd;
    logic [IDX_W-1:0] r_bs_madd;
    logic [1:0]       w_req;
    logic [1:0]       w_gnt;
    req_e             w_ptr;

    // The sequencer only requests once in RUN, so a start never competes on its own edge.
    assign w_req = {r_state == RUN, core_req};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req  (w_req),
        .i_hold (dg_hold),
        .o_gnt  (w_gnt),
        .o_ptr  (w_ptr)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bs_start) begin
                    w_state_nxt = (bs_cnt != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_gnt[1] && (r_cnt == CNT_W'(1))) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bs_dgsclt <= 1'b0;
            r_bs_iadd   <= '0;
            r_bs_madd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && bs_start) begin
                r_cnt       <= bs_cnt;
                r_bs_dgsclt <= bs_dgsclt;
                r_bs_iadd   <= bs_iadd;
                r_bs_madd   <= bs_madd;
            end else if (w_gnt[1]) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Output register: the access arbitrated at this edge is presented next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_dg_en     <= 1'b0;
            ps_dg_dgsclt <= 1'b0;
            ps_dg_mdfy   <= 1'b0;
            ps_dg_iadd   <= '0;
            ps_dg_madd   <= '0;
            core_gnt     <= 1'b0;
            bs_done      <= 1'b0;
        end else begin
            core_gnt <= w_gnt[0];
            bs_done  <= (r_state == DONE);
            if (w_gnt[0]) begin
                ps_dg_en     <= 1'b1;
                ps_dg_dgsclt <= core_dgsclt;
                ps_dg_mdfy   <= core_mdfy;
                ps_dg_iadd   <= core_iadd;
                ps_dg_madd   <= core_madd;
            end else if (w_gnt[1]) begin
                ps_dg_en     <= 1'b1;
                ps_dg_dgsclt <= r_bs_dgsclt;
                ps_dg_mdfy   <= 1'b0;
                ps_dg_iadd   <= r_bs_iadd;
                ps_dg_madd   <= r_bs_madd;
            end else begin
                ps_dg_en     <= 1'b0;
                ps_dg_dgsclt <= 1'b0;
                ps_dg_mdfy   <= 1'b0;
                ps_dg_iadd   <= '0;
                ps_dg_madd   <= '0;
            end
        end
    end

    assign bs_busy = (r_state != IDLE);
endmodule
